// File: rtl/mem_arbiter_if.sv
// Requester, memory and fill-return signals shared by mem_arbiter and its neighbours.
// master = the arbiter; slave = the requesters and memory model around it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned WORDS_PER_BLK = 8
);
  localparam int unsigned WW = $clog2(WORDS_PER_BLK);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic              fill_valid;
  logic [15:0]       fill_data;
  logic [WW-1:0]     fill_word;
  logic              fill_owner;
  logic              i_done;
  logic              d_done;
  logic              busy;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data, fill_word,
           fill_owner, i_done, d_done, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data, fill_word,
           fill_owner, i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between I-side line fills and D-side fills/writes,
// issuing burst reads back to back and passing returned words straight to the owner.
module mem_arbiter #(
  parameter int unsigned MEM_LAT       = 4,
  parameter int unsigned WORDS_PER_BLK = 8,
  parameter int unsigned ADDR_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned WW = $clog2(WORDS_PER_BLK);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] HALF_MASK = ~ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [WW:0]       issue_q, issue_d;
  logic [WW-1:0]     ret_q, ret_d;
  logic              win_d;
  logic              last_ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      issue_q      <= '0;
      ret_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      issue_q      <= issue_d;
      ret_q        <= ret_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    base_d         = base_q;
    wdata_d        = wdata_q;
    issue_d        = issue_q;
    ret_d          = ret_q;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_valid = 1'b0;
    bus.fill_data  = '0;
    bus.fill_word  = '0;
    bus.fill_owner = 1'b0;
    bus.i_done     = 1'b0;
    bus.d_done     = 1'b0;
    bus.busy       = (state_q != IDLE);
    // On a tie the side that did not win last time gets the port.
    win_d    = bus.d_req && (!bus.i_req || !last_grant_q);
    last_ret = (ret_q == WW'(WORDS_PER_BLK - 1));

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          last_grant_d = win_d;
          owner_d      = win_d;
          wdata_d      = bus.d_wdata;
          issue_d      = '0;
          ret_d        = '0;
          if (win_d && bus.d_wr) begin
            state_d = WRITE;
            base_d  = bus.d_addr & HALF_MASK;
          end else begin
            state_d = FILL;
            base_d  = (win_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
          end
        end
      end
      FILL: begin
        if (issue_q != (WW + 1)'(WORDS_PER_BLK)) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q | (ADDR_W'(issue_q[WW-1:0]) << 1);
          issue_d      = issue_q + (WW + 1)'(1);
        end
        if (bus.mem_valid) begin
          bus.fill_valid = 1'b1;
          bus.fill_data  = bus.mem_rdata;
          bus.fill_word  = ret_q;
          bus.fill_owner = owner_q;
          ret_d          = ret_q + WW'(1);
          if (last_ret) begin
            bus.i_done = !owner_q;
            bus.d_done = owner_q;
            state_d    = IDLE;
          end
        end
      end
      WRITE: begin
        if (issue_q == '0) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = base_q;
          bus.mem_wdata = wdata_q;
          issue_d       = (WW + 1)'(1);
        end else if (bus.mem_valid) begin
          bus.d_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory contract the return counting relies on.
  a_mem_resp: assert property (@(posedge clk) disable iff (rst)
    bus.mem_en |-> ##MEM_LAT bus.mem_valid);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed grant table, multi-cycle corner sequences and random
// traffic, all checked cycle by cycle against a transaction-timing reference model.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;
  localparam int unsigned N   = 8;

  typedef struct {
    bit          i, d, dwr;
    logic [15:0] ia, da, wd;
    bit          e_owner;
    logic [15:0] e_base;
    bit          e_wr;
    int unsigned e_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mem_arbiter_if #(.ADDR_W(16), .WORDS_PER_BLK(N)) bus ();

  mem_arbiter #(.MEM_LAT(LAT), .WORDS_PER_BLK(N), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfun(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h31};
  endfunction

  // Memory model: fixed-latency response pipeline, never cleared by reset.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bus.mem_en};
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign bus.mem_valid = pv[LAT-1] | stray;
  assign bus.mem_rdata = pv[LAT-1] ? memfun(pa[LAT-1]) : 16'hDEAD;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 60)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: who owns the port and how many cycles since its grant edge.
  bit          m_busy, m_last, m_owner, m_wr;
  int unsigned m_cyc, m_base, m_wdata;
  bit          exp_id, exp_dd;

  task automatic advance();
    bit          win;
    int unsigned a;
    if (m_busy) begin
      if (m_cyc == (m_wr ? LAT + 1 : LAT + N)) m_busy = 0;
      else m_cyc++;
    end else if (bus.i_req || bus.d_req) begin
      win     = (bus.i_req && bus.d_req) ? !m_last : bus.d_req;
      m_last  = win;
      m_owner = win;
      m_busy  = 1;
      m_cyc   = 1;
      m_wr    = win && bus.d_wr;
      m_wdata = bus.d_wdata;
      a       = win ? bus.d_addr : bus.i_addr;
      m_base  = m_wr ? a - a % 2 : a - a % (2 * N);
    end
  endtask

  task automatic check();
    int unsigned e_en, e_wr, e_addr, e_wd, e_fv, e_fw, e_fd, e_fo;
    e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_fv = 0; e_fw = 0; e_fd = 0; e_fo = 0;
    exp_id = 0; exp_dd = 0;
    if (m_busy && !m_wr) begin
      if (m_cyc <= N) begin
        e_en   = 1;
        e_addr = m_base + 2 * (m_cyc - 1);
      end
      if (m_cyc > LAT && m_cyc <= LAT + N) begin
        e_fv = 1;
        e_fw = m_cyc - LAT - 1;
        e_fd = memfun(16'(m_base + 2 * e_fw));
        e_fo = m_owner;
      end
      if (m_cyc == LAT + N) begin
        exp_id = !m_owner;
        exp_dd = m_owner;
      end
    end else if (m_busy) begin
      if (m_cyc == 1) begin
        e_en = 1; e_wr = 1; e_addr = m_base; e_wd = m_wdata;
      end
      exp_dd = (m_cyc == LAT + 1);
    end
    chk("busy", bus.busy, m_busy);
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_wr", bus.mem_wr, e_wr);
    chk("fill_valid", bus.fill_valid, e_fv);
    chk("i_done", bus.i_done, exp_id);
    chk("d_done", bus.d_done, exp_dd);
    if (e_en != 0) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wd);
    end else if (!m_busy || !m_wr) begin
      chk("mem_wdata_idle", bus.mem_wdata, 0);
    end
    if (e_fv != 0) begin
      chk("fill_data", bus.fill_data, e_fd);
      chk("fill_word", bus.fill_word, e_fw);
      chk("fill_owner", bus.fill_owner, e_fo);
    end
  endtask

  task automatic step();
    advance();
    @(negedge clk);
    check();
  endtask

  function automatic vec_t mk(bit i, bit d, bit w, logic [15:0] ia, logic [15:0] da,
                              logic [15:0] wd, bit o, logic [15:0] b, bit ew, int unsigned c);
    vec_t v;
    v.i = i; v.d = d; v.dwr = w; v.ia = ia; v.da = da; v.wd = wd;
    v.e_owner = o; v.e_base = b; v.e_wr = ew; v.e_cyc = c;
    return v;
  endfunction

  vec_t        tbl [11];
  int unsigned rs [2];

  initial begin
    int unsigned nfv, o_cyc, o_addr, o_wr, o_wd, o_owner;
    bit          got, seen;

    tbl[0]  = mk(1, 0, 0, 16'h1236, 16'h0000, 16'h0000, 0, 16'h1230, 0, 12);
    tbl[1]  = mk(1, 1, 0, 16'h2000, 16'h0040, 16'h0000, 1, 16'h0040, 0, 12);
    tbl[2]  = mk(1, 1, 0, 16'h2000, 16'h0040, 16'h0000, 0, 16'h2000, 0, 12);
    tbl[3]  = mk(1, 1, 0, 16'h3006, 16'h0050, 16'h0000, 1, 16'h0050, 0, 12);
    tbl[4]  = mk(1, 1, 0, 16'h3006, 16'h0066, 16'h0000, 0, 16'h3000, 0, 12);
    tbl[5]  = mk(0, 1, 1, 16'h0000, 16'h0103, 16'hBEEF, 1, 16'h0102, 1, 5);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 16'h00FF, 16'h0000, 1, 16'h00F0, 0, 12);
    tbl[7]  = mk(1, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 16'hFFF0, 0, 12);
    tbl[8]  = mk(0, 1, 1, 16'h0000, 16'hFFFF, 16'h1234, 1, 16'hFFFE, 1, 5);
    tbl[9]  = mk(1, 1, 1, 16'h0800, 16'h0200, 16'h5555, 0, 16'h0800, 0, 12);
    tbl[10] = mk(1, 1, 1, 16'h0800, 16'h0200, 16'h5555, 1, 16'h0200, 1, 5);

    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    m_busy = 0; m_last = 0; m_owner = 0; m_wr = 0; m_cyc = 0; m_base = 0; m_wdata = 0;

    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_mem_en", bus.mem_en, 0);
    chk("reset_fill_valid", bus.fill_valid, 0);
    chk("reset_done", {bus.i_done, bus.d_done}, 0);
    rst = 0;

    for (int e = 0; e < 11; e++) begin
      bus.i_req = tbl[e].i; bus.d_req = tbl[e].d; bus.d_wr = tbl[e].dwr;
      bus.i_addr = tbl[e].ia; bus.d_addr = tbl[e].da; bus.d_wdata = tbl[e].wd;
      got = 0; seen = 0; o_cyc = 0; o_addr = 0; o_wr = 0; o_wd = 0; o_owner = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (bus.busy) o_cyc++;
        if (bus.mem_en && !seen) begin
          seen = 1; o_addr = bus.mem_addr; o_wr = bus.mem_wr; o_wd = bus.mem_wdata;
        end
        if (bus.i_done || bus.d_done) begin
          got = 1; o_owner = bus.d_done;
        end
      end
      chk("tbl_done", got, 1);
      chk("tbl_owner", o_owner, tbl[e].e_owner);
      chk("tbl_base", o_addr, tbl[e].e_base);
      chk("tbl_wr", o_wr, tbl[e].e_wr);
      chk("tbl_wdata", o_wd, tbl[e].e_wr ? tbl[e].wd : 16'h0000);
      chk("tbl_cycles", o_cyc, tbl[e].e_cyc);
      if (o_owner != 0) bus.d_req = 0;
      else bus.i_req = 0;
    end
    bus.i_req = 0; bus.d_req = 0; bus.d_wr = 0;
    step();

    // Requester withdraws after its first word; the line must still complete.
    bus.i_req = 1; bus.i_addr = 16'h4446; nfv = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (bus.fill_valid) begin nfv++; bus.i_req = 0; end
      if (bus.i_done) got = 1;
    end
    chk("drop_words", nfv, N);
    chk("drop_done", got, 1);
    step();
    chk("drop_idle", bus.busy, 0);

    // Asynchronous reset after three words; stale responses must be dropped.
    bus.i_req = 1; bus.i_addr = 16'h1236; nfv = 0;
    for (int c = 0; c < 40 && nfv < 3; c++) begin
      step();
      if (bus.fill_valid) nfv++;
    end
    chk("rst_pre_words", nfv, 3);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    chk("rst_fill_word", bus.fill_word, 0);
    chk("rst_done", {bus.i_done, bus.d_done}, 0);
    bus.i_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_busy = 0; m_last = 0;
    repeat (6) step();

    // Random traffic; rs: 0 idle, 1 requesting, 2 withdrawn while being served.
    rs[0] = 0; rs[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rs[0] == 0 && $urandom_range(0, 3) == 0) begin
        rs[0] = 1; bus.i_addr = 16'($urandom);
      end
      if (rs[1] == 0 && $urandom_range(0, 3) == 0) begin
        rs[1] = 1; bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
        bus.d_wr = ($urandom_range(0, 2) == 0);
      end
      if (m_busy && rs[m_owner] == 1 && $urandom_range(0, 7) == 0) rs[m_owner] = 2;
      bus.i_req = (rs[0] == 1);
      bus.d_req = (rs[1] == 1);
      stray = !m_busy && !bus.i_req && !bus.d_req && ($urandom_range(0, 2) == 0);
      step();
      if (exp_id) rs[0] = 0;
      if (exp_dd) rs[1] = 0;
    end
    stray = 0; bus.i_req = 0; bus.d_req = 0;
    for (int c = 0; c < 30 && m_busy; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported, multi-cycle main memory between the instruction-fetch cache-fill requester (I) and the data-side requester (D).
- D may request a cache-line fill or a single-word write-through.
- The block sequences burst reads and counts returned words, then presents fill data to the owning cache. It sits between the fetch/memory-stage cache controllers and the main memory model.

Parameters:
- MEM_LAT, 4, cycles from a mem_en read/write issue to its mem_valid.
- WORDS_PER_BLK, 8, 16-bit words per cache line (power of 2, >= 2).
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  I fill request, level, held until i_done
- i_addr  in  ADDR_W  I miss byte address
- d_req  in  1  D request, level, held until d_done
- d_wr  in  1  1=single-word write, 0=line fill; sampled at grant
- d_addr  in  ADDR_W  D byte address
- d_wdata  in  16  D write data
- mem_en  out  1  memory access strobe, one access per cycle
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  read data, valid with mem_valid
- mem_valid  in  1  response for the access issued MEM_LAT cycles earlier
- fill_valid  out  1  fill_data is valid this cycle
- fill_data  out  16  returned word
- fill_word  out  log2(WORDS_PER_BLK)  word index within the line
- fill_owner  out  1  0=I, 1=D
- i_done  out  1  one-cycle pulse, I fill complete
- d_done  out  1  one-cycle pulse, D fill or write complete
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, last_grant=I, issue and return counters=0, and all outputs 0. Reset mid-operation abandons the transaction.
- mem_valid is ignored in IDLE, so stale responses arriving after reset or abort are dropped.
- States: IDLE, FILL, WRITE.
- Arbitration happens only in IDLE.
  - Only one requester asserted: grant it.
  - Both asserted: grant the requester that is not last_grant. After reset, D wins the first tie.
  - last_grant updates on each grant.
  - Grant cycle: latch owner, base = addr with low log2(2*WORDS_PER_BLK) bits cleared (fill), or addr with bit0 cleared (write). Latch d_wr and d_wdata. Move to FILL or WRITE. No memory access is issued in the grant cycle.
- FILL:
  - Issues WORDS_PER_BLK reads on consecutive cycles: mem_en=1, mem_wr=0, mem_addr=base+2*k for k=0..N-1.
  - Each mem_valid produces fill_valid=1, fill_data=mem_rdata and fill_word=return count, in the same cycle (combinational pass-through gated by state). The return count then increments.
  - When the return count reaches N: pulse the owner's done with the last fill_valid, then go to IDLE.
  - Total occupancy is 1+N+MEM_LAT-1 cycles after the grant edge.
- WRITE:
  - Issues one access: mem_en=1, mem_wr=1, mem_addr=base, mem_wdata=latched data.
  - Waits for mem_valid, then pulses d_done in that cycle (fill_valid stays 0) and returns to IDLE.
- A requester dropping its req mid-transaction is ignored: the transaction completes and done still pulses.
- A requester must deassert req in the cycle after done. If req is still high in IDLE, it is re-arbitrated as a new request.
- The return counter wraps modulo N. mem_valid beyond N returns is a protocol error: ignored, no output.
- mem_en=0 whenever no issue is pending, and mem_wdata=0 when not writing.

Test Plan:
- Reset, then i_req=1 with i_addr=0x1236 and MEM_LAT=4: busy=1. Reads to 0x1230..0x123E on 8 consecutive cycles. fill_word 0..7 with fill_owner=0. i_done coincides with fill_word=7, 12 cycles after the grant edge.
- i_req and d_req rise together, with d_wr=0 and d_addr=0x0040: D is served first (fill 0x0040..0x004E, fill_owner=1, d_done). I is granted in the IDLE cycle after d_done.
- Both requests held continuously for 4 transactions: grants alternate D, I, D, I. Neither requester waits for more than one other transaction.
- d_req=1, d_wr=1, d_addr=0x0103, d_wdata=0xBEEF: single mem_en with mem_wr=1, mem_addr=0x0102, mem_wdata=0xBEEF. d_done pulses 4 cycles later and fill_valid stays 0.
- rst asserted asynchronously in the middle of a fill, after 3 words returned: outputs go 0 immediately, state=IDLE. Remaining mem_valid pulses produce no fill_valid.
- The requester drops i_req after the first fill_valid: all 8 words are still delivered and i_done still pulses. busy=0 the following cycle.
